runway_scheduler: RTL

- Arbitrates runway use between the takeoff-queue head and the landing-queue head, and owns the occupancy state of both runways.
- Issues one clear or divert decision at a time through a valid/ready grant port, which feeds the reply formatter.
- Matches release requests against runway owners and force-releases runways held longer than TIMEOUT cycles.
- Sits between the request-decode FSM/queues and the UART reply path.

---
 rtl/runway_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/runway_scheduler.sv
// Runway arbiter: picks takeoff/landing heads, locks runways, offers one
// clear/divert decision at a time, and frees runways on release or timeout.
module runway_scheduler #(
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 200
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            to_valid,
  input  logic [ID_W-1:0] to_id,
  output logic            to_ready,
  input  logic            ld_valid,
  input  logic [ID_W-1:0] ld_id,
  output logic            ld_ready,
  input  logic            rel_valid,
  input  logic [ID_W-1:0] rel_id,
  input  logic            rel_runway,
  input  logic            emergency,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_runway,
  output logic [1:0]      gnt_kind,
  input  logic            gnt_ready,
  output logic [1:0]      runway_busy,
  output logic [ID_W-1:0] owner0,
  output logic [ID_W-1:0] owner1,
  output logic            rel_err,
  output logic [1:0]      timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] K_TO = 2'b00, K_LD = 2'b01, K_DIV = 2'b10;

  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_nxt;

  logic            rr_last;  // 1 = last clear was a landing
  logic [1:0]      busy;
  logic [ID_W-1:0] owner [2];
  logic [TW-1:0]   timer [2];
  logic [1:0]      rel_hit, tmo_hit, lock;

  logic            sel_to, sel_ld, sel_rwy, accept;
  logic [1:0]      sel_kind;
  logic [ID_W-1:0] sel_id;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = OFFER;
      OFFER:   if (gnt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Selection sees the current lock state, so a runway freed this cycle
  // is only grantable from the next one.
  always_comb begin
    sel_to   = 1'b0;
    sel_ld   = 1'b0;
    sel_kind = K_TO;
    sel_rwy  = 1'b0;
    sel_id   = to_id;
    if (state == IDLE && reset_n) begin
      if (emergency) begin
        if (ld_valid) begin
          sel_ld   = 1'b1;
          sel_kind = K_DIV;
          sel_id   = ld_id;
        end
      end else if (busy != 2'b11) begin
        sel_rwy = busy[0];
        if (ld_valid && (!to_valid || !rr_last)) begin
          sel_ld   = 1'b1;
          sel_kind = K_LD;
          sel_id   = ld_id;
        end else if (to_valid) begin
          sel_to = 1'b1;
        end
      end
    end
    accept    = sel_to | sel_ld;
    to_ready  = sel_to;
    ld_ready  = sel_ld;
    gnt_valid = (state == OFFER);
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      gnt_id     <= '0;
      gnt_runway <= 1'b0;
      gnt_kind   <= K_TO;
      rr_last    <= 1'b0;
    end else if (accept) begin
      gnt_id     <= sel_id;
      gnt_runway <= sel_rwy;
      gnt_kind   <= sel_kind;
      if (sel_kind != K_DIV) rr_last <= sel_ld;
    end

  // A matching release on the timeout edge wins and suppresses the pulse.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      rel_hit[r] = rel_valid && (rel_runway == 1'(r)) && busy[r] && (rel_id == owner[r]);
      tmo_hit[r] = busy[r] && (timer[r] == TW'(TIMEOUT - 1)) && !rel_hit[r];
      lock[r]    = accept && (sel_kind != K_DIV) && (sel_rwy == 1'(r));
    end
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      busy    <= 2'b00;
      rel_err <= 1'b0;
      timeout <= 2'b00;
      for (int r = 0; r < 2; r++) begin
        owner[r] <= '0;
        timer[r] <= '0;
      end
    end else begin
      rel_err <= rel_valid && !(|rel_hit);
      timeout <= tmo_hit;
      for (int r = 0; r < 2; r++) begin
        if (rel_hit[r] || tmo_hit[r]) begin
          busy[r]  <= 1'b0;
          timer[r] <= '0;
        end else if (lock[r]) begin
          busy[r]  <= 1'b1;
          owner[r] <= sel_id;
          timer[r] <= '0;
        end else if (busy[r]) begin
          timer[r] <= timer[r] + 1'b1;
        end
      end
    end

  assign runway_busy = busy;
  assign owner0      = owner[0];
  assign owner1      = owner[1];
endmodule
